// File: rtl/mem_stage_unit.sv
// Memory stage with MEM/WB register: multi-cycle data-memory access that stalls upstream.
// Optional MEM_WB_FWD_EN: forward the WB result into store data when it targets the store source register.
module mem_stage_unit #(
  parameter int ADDR_W     = 8,
  parameter int ACCESS_LAT = 2
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  RA2M,
  output logic        StallM,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic        AlignErrW
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam bit         MULTI    = (ACCESS_LAT > 1);
  localparam logic [2:0] CNT_INIT = MULTI ? 3'(ACCESS_LAT - 2) : 3'd0;

  state_t              state;
  state_t              state_next;
  logic [2:0]          cnt;
  logic [2:0]          cnt_next;
  logic                mem_op;
  logic                commit;
  logic [31:0]         store_data_first;
  logic [ADDR_W-1:0]   hold_idx;
  logic [31:0]         hold_data;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_data;
  logic [31:0]         rd_word;
  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  assign mem_op = MemWriteM | MemtoRegM;

`ifdef MEM_WB_FWD_EN
  logic fwd_hit;
  assign fwd_hit = RegWriteW && (WA3W == RA2M) && (WA3W != 4'hF);
  assign store_data_first = fwd_hit ? (MemtoRegW ? ReadDataW : ALUOutW) : WriteDataM;
`else
  logic unused_ra2;
  assign unused_ra2 = ^RA2M;
  assign store_data_first = WriteDataM;
`endif

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (mem_op && MULTI) begin
          state_next = WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt != 3'd0) cnt_next = cnt - 3'd1;
        else             state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    StallM = 1'b0;
    commit = 1'b0;
    if (nRESET) begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (MULTI) StallM = 1'b1;
            else       commit = 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 3'd0) StallM = 1'b1;
          else             commit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address and store data are frozen on the first cycle so the forwarding choice survives later W bubbles.
  always_ff @(posedge CLK) begin
    if (state == IDLE && mem_op) begin
      hold_idx  <= ALUOutM[ADDR_W+1:2];
      hold_data <= store_data_first;
    end
  end

  assign acc_idx  = (state == WAIT) ? hold_idx  : ALUOutM[ADDR_W+1:2];
  assign acc_data = (state == WAIT) ? hold_data : store_data_first;
  assign rd_word  = mem[acc_idx];

  always_ff @(posedge CLK) begin
    if (commit && MemWriteM) mem[acc_idx] <= acc_data;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET || StallM) begin
      PCSrcW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= 32'd0;
      ALUOutW   <= 32'd0;
      WA3W      <= 4'd0;
      AlignErrW <= 1'b0;
    end else begin
      PCSrcW    <= PCSrcM;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      ReadDataW <= (commit && MemtoRegM) ? rd_word : 32'd0;
      ALUOutW   <= ALUOutM;
      WA3W      <= WA3M;
      AlignErrW <= commit && (ALUOutM[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: two instances (ACCESS_LAT 3 and 1) against a transaction-level model.
module tb_mem_stage_unit;

  localparam int LAT0  = 3;
  localparam int LAT1  = 1;
  localparam int K_NONE = 0;
  localparam int K_ZERO = 1;
  localparam int K_BUB  = 2;
  localparam int K_OP   = 3;

  typedef struct {
    int          kind;
    logic        pc, rw, m2r, ae;
    logic [3:0]  wa3;
    logic [31:0] alu, rd;
    bit          rd_known;
  } wexp_t;

  typedef struct {
    bit    stall;
    wexp_t w;
  } item_t;

  typedef struct {
    bit          pc, rw, mw, m2r;
    logic [31:0] alu, wd;
    logic [3:0]  wa3, ra2;
  } op_t;

  logic        CLK = 1'b0;
  logic        nres      [2];
  logic        pcsrc_m   [2];
  logic        regwrite_m[2];
  logic        memwrite_m[2];
  logic        memtoreg_m[2];
  logic [31:0] aluout_m  [2];
  logic [31:0] wdata_m   [2];
  logic [3:0]  wa3_m     [2];
  logic [3:0]  ra2_m     [2];
  logic        stall_o   [2];
  logic        pcsrc_w   [2];
  logic        regwrite_w[2];
  logic        memtoreg_w[2];
  logic [31:0] rdata_w   [2];
  logic [31:0] aluout_w  [2];
  logic [3:0]  wa3_w     [2];
  logic        alignerr_w[2];

  item_t       sb0[$];
  item_t       sb1[$];
  wexp_t       cur_w [2];
  logic [31:0] mdl   [2][256];
  bit          known [2][256];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 CLK = ~CLK;

  mem_stage_unit #(.ADDR_W(8), .ACCESS_LAT(LAT0)) u_dut0 (
    .CLK(CLK), .nRESET(nres[0]), .PCSrcM(pcsrc_m[0]), .RegWriteM(regwrite_m[0]),
    .MemWriteM(memwrite_m[0]), .MemtoRegM(memtoreg_m[0]), .ALUOutM(aluout_m[0]),
    .WriteDataM(wdata_m[0]), .WA3M(wa3_m[0]), .RA2M(ra2_m[0]), .StallM(stall_o[0]),
    .PCSrcW(pcsrc_w[0]), .RegWriteW(regwrite_w[0]), .MemtoRegW(memtoreg_w[0]),
    .ReadDataW(rdata_w[0]), .ALUOutW(aluout_w[0]), .WA3W(wa3_w[0]), .AlignErrW(alignerr_w[0])
  );

  mem_stage_unit #(.ADDR_W(8), .ACCESS_LAT(LAT1)) u_dut1 (
    .CLK(CLK), .nRESET(nres[1]), .PCSrcM(pcsrc_m[1]), .RegWriteM(regwrite_m[1]),
    .MemWriteM(memwrite_m[1]), .MemtoRegM(memtoreg_m[1]), .ALUOutM(aluout_m[1]),
    .WriteDataM(wdata_m[1]), .WA3M(wa3_m[1]), .RA2M(ra2_m[1]), .StallM(stall_o[1]),
    .PCSrcW(pcsrc_w[1]), .RegWriteW(regwrite_w[1]), .MemtoRegW(memtoreg_w[1]),
    .ReadDataW(rdata_w[1]), .ALUOutW(aluout_w[1]), .WA3W(wa3_w[1]), .AlignErrW(alignerr_w[1])
  );

  function automatic int lat(input int l);
    return (l == 0) ? LAT0 : LAT1;
  endfunction

  function automatic wexp_t mk_w(input int kind);
    wexp_t w;
    w.kind = kind; w.pc = 0; w.rw = 0; w.m2r = 0; w.ae = 0;
    w.wa3 = 0; w.alu = 0; w.rd = 0; w.rd_known = 0;
    return w;
  endfunction

  function automatic op_t mk_op(input bit pc, input bit rw, input bit mw, input bit m2r,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [3:0] wa3, input logic [3:0] ra2);
    op_t o;
    o.pc = pc; o.rw = rw; o.mw = mw; o.m2r = m2r;
    o.alu = alu; o.wd = wd; o.wa3 = wa3; o.ra2 = ra2;
    return o;
  endfunction

  // Monitor: each negedge pops one item per lane and checks StallM and the visible W register.
  task automatic check_output(input int l, input item_t it);
    logic [71:0] act, exp_v, mask;
    n_cmp++;
    if (stall_o[l] !== it.stall) begin
      n_bad++;
      $display("[TB] FAIL lane%0d stall @%0t: got %b want %b", l, $time, stall_o[l], it.stall);
    end
    if (it.w.kind != K_NONE) begin
      act   = {pcsrc_w[l], regwrite_w[l], memtoreg_w[l], alignerr_w[l], wa3_w[l], aluout_w[l], rdata_w[l]};
      exp_v = {it.w.pc, it.w.rw, it.w.m2r, it.w.ae, it.w.wa3, it.w.alu, it.w.rd};
      if (it.w.kind == K_ZERO)     mask = {72{1'b1}};
      else if (it.w.kind == K_BUB) mask = {4'hF, 68'd0};
      else                         mask = {40'hFF_FFFF_FFFF, it.w.rd_known ? 32'hFFFF_FFFF : 32'd0};
      n_cmp++;
      if ((act & mask) !== (exp_v & mask)) begin
        n_bad++;
        $display("[TB] FAIL lane%0d wreg @%0t: got %h want %h (mask %h)", l, $time, act, exp_v, mask);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (sb0.size() != 0) check_output(0, sb0.pop_front());
    if (sb1.size() != 0) check_output(1, sb1.pop_front());
  end

  // One clock cycle: record what this cycle should show, then advance to just after the edge.
  task automatic step(input int l, input bit stall, input wexp_t wnext);
    item_t it;
    it.stall = stall;
    it.w     = cur_w[l];
    if (l == 0) sb0.push_back(it);
    else        sb1.push_back(it);
    @(posedge CLK);
    #1;
    cur_w[l] = wnext;
  endtask

  task automatic drive(input int l, input op_t op);
    pcsrc_m[l]    = op.pc;
    regwrite_m[l] = op.rw;
    memwrite_m[l] = op.mw;
    memtoreg_m[l] = op.m2r;
    aluout_m[l]   = op.alu;
    wdata_m[l]    = op.wd;
    wa3_m[l]      = op.wa3;
    ra2_m[l]      = op.ra2;
  endtask

  task automatic reset_cycle(input int l);
    nres[l] = 1'b0;
    drive(l, mk_op(0, 1, 0, 0, 32'h55, 32'h0, 4'd1, 4'd0));
    step(l, 0, mk_w(K_ZERO));
  endtask

  // Issue one op; with abort set, reset is asserted on the cycle after the op's first edge.
  task automatic apply_stimulus(input int l, input op_t op, input bit abort);
    int          nst;
    int          idx;
    bit          mem, sd_known;
    logic [31:0] sd;
    wexp_t       w;
    nres[l] = 1'b1;
    drive(l, op);
    mem = op.mw | op.m2r;
    nst = mem ? lat(l) - 1 : 0;
    if (abort && nst > 0) begin
      step(l, 1, mk_w(K_BUB));
      reset_cycle(l);
      nres[l] = 1'b1;
      return;
    end
    idx = int'(op.alu[9:2]);
    sd = op.wd;
    sd_known = 1;
`ifdef MEM_WB_FWD_EN
    if (cur_w[l].kind == K_OP && cur_w[l].rw && cur_w[l].wa3 == op.ra2 && cur_w[l].wa3 != 4'hF) begin
      if (cur_w[l].m2r) begin
        sd = cur_w[l].rd;
        sd_known = cur_w[l].rd_known;
      end else begin
        sd = cur_w[l].alu;
      end
    end
`endif
    w = mk_w(K_OP);
    w.pc = op.pc; w.rw = op.rw; w.m2r = op.m2r; w.wa3 = op.wa3; w.alu = op.alu;
    w.ae = mem && (op.alu[1:0] != 2'b00);
    w.rd = mdl[l][idx];
    w.rd_known = op.m2r && known[l][idx];
    if (op.mw) begin
      mdl[l][idx]   = sd;
      known[l][idx] = sd_known;
    end
    for (int i = 0; i < nst; i++) step(l, 1, mk_w(K_BUB));
    step(l, 0, w);
    if (abort) begin
      reset_cycle(l);
      nres[l] = 1'b1;
    end
  endtask

  task automatic run_lane(input int l);
    op_t         op;
    int          kind, wsel;
    logic [31:0] addr;
    @(posedge CLK);
    #1;
    reset_cycle(l);
    reset_cycle(l);
    apply_stimulus(l, mk_op(0, 1, 0, 0, 32'h55, 32'h0, 4'd1, 4'd0), 0);
    for (int i = 0; i < 16; i++)
      apply_stimulus(l, mk_op(0, 0, 1, 0, 32'(i * 4), $urandom, 4'd0, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 4'd0, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 1, 0, 1, 32'h10, 32'h0, 4'd2, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 0, 1, 0, 32'h400, 32'h1234, 4'd0, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 1, 0, 1, 32'h000, 32'h0, 4'd4, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 1, 0, 1, 32'h013, 32'h0, 4'd5, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 0, 1, 0, 32'h20, 32'h5555, 4'd0, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 0, 1, 0, 32'h20, 32'hAAAA, 4'd0, 4'd0), 1);
    apply_stimulus(l, mk_op(0, 1, 0, 1, 32'h20, 32'h0, 4'd6, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 1, 0, 0, 32'h77, 32'h0, 4'd3, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 0, 1, 0, 32'h24, 32'h0, 4'd0, 4'd3), 0);
    apply_stimulus(l, mk_op(0, 1, 0, 1, 32'h24, 32'h0, 4'd7, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 1, 0, 0, 32'h99, 32'h0, 4'hF, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 0, 1, 0, 32'h28, 32'h11, 4'd0, 4'hF), 0);
    apply_stimulus(l, mk_op(0, 1, 0, 1, 32'h28, 32'h0, 4'd8, 4'd0), 0);
    apply_stimulus(l, mk_op(1, 1, 1, 1, 32'h2C, 32'hC0FFEE, 4'd9, 4'd0), 0);
    apply_stimulus(l, mk_op(0, 1, 0, 1, 32'h2C, 32'h0, 4'd9, 4'd0), 0);
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(3);
      wsel = $urandom_range(15);
      addr = ($urandom << 10) | 32'(wsel << 2) | (($urandom_range(3) == 0) ? 32'($urandom_range(3)) : 32'd0);
      op = mk_op($urandom_range(7) == 0, 1'($urandom), 0, 0, $urandom, $urandom,
                 4'($urandom), ($urandom_range(1) == 0) ? cur_w[l].wa3 : 4'($urandom));
      if (kind == 1) begin op.m2r = 1; op.rw = 1; op.alu = addr; end
      if (kind == 2) begin op.mw = 1; op.rw = 0; op.alu = addr; end
      if (kind == 3) begin op.mw = 1; op.m2r = 1; op.rw = 1; op.alu = addr; end
      apply_stimulus(l, op, 0);
    end
    for (int i = 0; i < 2; i++)
      apply_stimulus(l, mk_op(0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0), 0);
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      nres[l] = 1'b0;
      drive(l, mk_op(0, 1, 0, 0, 32'h55, 32'h0, 4'd1, 4'd0));
      cur_w[l] = mk_w(K_NONE);
      for (int a = 0; a < 256; a++) begin
        mdl[l][a]   = 32'h0;
        known[l][a] = 1'b0;
      end
    end
    fork
      run_lane(0);
      run_lane(1);
    join
    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Memory stage of the 5-stage ARM-style pipeline. It consumes the EX/MEM register outputs (…M signals), performs data-memory loads and stores with a configurable multi-cycle access latency, and stalls upstream stages while an access is in flight.
- It contains the MEM/WB pipeline register, so every …W output is registered and feeds writeback.

Parameters:
- ADDR_W, 8, log2 of data-memory depth in 32-bit words (256 words).
- ACCESS_LAT, 2, cycles per load/store, legal range 1..8; 1 means no stall.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- nRESET  in  1  synchronous active-low reset.
- PCSrcM  in  1  branch/PC-write flag from EX/MEM.
- RegWriteM  in  1  register-write flag.
- MemWriteM  in  1  store request.
- MemtoRegM  in  1  load request (writeback selects memory data).
- ALUOutM  in  32  byte address for memory ops, else the ALU result.
- WriteDataM  in  32  store data.
- WA3M  in  4  destination register.
- RA2M  in  4  store-data source register (forwarding compare).
- StallM  out  1  hold EX/MEM and earlier stages.
- PCSrcW  out  1  registered PCSrc.
- RegWriteW  out  1  registered RegWrite.
- MemtoRegW  out  1  registered MemtoReg.
- ReadDataW  out  32  load data.
- ALUOutW  out  32  registered ALUOutM.
- WA3W  out  4  registered WA3M.
- AlignErrW  out  1  memory op had a nonzero ALUOutM[1:0].

Behaviour:
- Reset: with nRESET=0 at a posedge, all …W outputs go to 0, FSM goes to IDLE, and cnt goes to 0. StallM is 0 while nRESET=0. Memory array contents are not reset.
- Mem op: MemWriteM | MemtoRegM. Word index = ALUOutM[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the depth. ALUOutM[1:0] is ignored for the access itself, which is always a full word.
- FSM states: IDLE, WAIT. Down-counter cnt is 3 bits wide.
- IDLE, no mem op: StallM=0. The W register captures the M inputs at the posedge (1-cycle latency).
- IDLE, mem op, ACCESS_LAT=1: StallM=0. The access commits at this posedge.
- IDLE, mem op, ACCESS_LAT>1: StallM=1. Next state WAIT, cnt<=ACCESS_LAT-2. Store data and address are latched into hold registers on this edge.
- WAIT, cnt!=0: StallM=1, cnt<=cnt-1.
- WAIT, cnt==0: StallM=0. The access commits at this posedge and the next state is IDLE.
- Total stall: ACCESS_LAT-1 cycles per mem op. The op occupies MEM for ACCESS_LAT cycles.
- Bubbles: in any cycle with StallM=1, the W register loads a bubble (RegWriteW=0, PCSrcW=0, MemtoRegW=0, AlignErrW=0; data fields don't-care, drive 0).
- Commit: a store writes the memory exactly once, on the commit edge. A load samples the array combinationally at the commit edge into ReadDataW.
- Load and store in the same op (both flags set): read-before-write. ReadDataW gets the old contents, the store data is written, and MemtoRegW passes through as given.
- Back-to-back ops: a store followed by a load to the same word returns the new data, because the store commits before the load's commit edge.
- AlignErrW is 1 for a committed mem op with ALUOutM[1:0]!=0, else 0. The access still proceeds.
- Reset mid-access: an in-flight store is abandoned and never written. The FSM returns to IDLE.
- The M inputs must stay stable while StallM=1, since upstream holds them. The block still uses the latched store data and address at commit.

Optional Feature:
- MEM_WB_FWD_EN, with macro defined: store-data forwarding from WB. On the first cycle of a store, if RegWriteW=1, WA3W==RA2M and WA3W!=4'hF, the latched store data is (MemtoRegW ? ReadDataW : ALUOutW) instead of WriteDataM. The decision is made only on that first cycle, so later bubbles in W do not cancel it.
- Without the macro: the latched store data is always WriteDataM and RA2M is unused.

Test Plan:
- Reset with nRESET=0 for 2 cycles while feeding RegWriteM=1 and ALUOutM=32'h55 -> all W outputs 0 and StallM=0; after release, the next cycle gives ALUOutW=32'h55 and RegWriteW=1.
- ACCESS_LAT=3: store 32'hDEADBEEF to address 0x10, then load from 0x10 -> StallM high 2 cycles for each op; the load gives ReadDataW=32'hDEADBEEF with MemtoRegW=1; W shows bubbles during stalls.
- Address wrap, ADDR_W=8: store 32'h1234 to 0x400, then load from 0x000 -> ReadDataW=32'h1234. Load from 0x013 -> AlignErrW=1 and data from word 4.
- ACCESS_LAT=3: reset asserted in the second cycle of a store of 32'hAAAA to 0x20 -> no write; a later load of 0x20 returns the prior value (e.g. 0).
- MEM_WB_FWD_EN defined: ADD writing R3=32'h77, then STR R3 with WriteDataM=32'h0 and RA2M=3 -> memory holds 32'h77. Undefined: memory holds 32'h0. With WA3W=4'hF: no forwarding.
- ACCESS_LAT=1: alternating ALU op / load / store at full rate -> StallM never 1 and each op reaches W one cycle later.
